approx_error_monitor: RTL and testbench

Response-side companion to the exhaustive stimulus benches for the approximate ISCAS-85 circuits. It consumes a stream of (golden, approximate) primary-output word pairs, one per applied input vector, and accumulates error metrics in hardware. Metrics are error rate, Hamming distance, absolute numeric error and worst-case error. It sits after the golden and approximate netlists in an FPGA or emulation error-evaluation harness. Results are held until the next run.

---
 rtl/approx_error_monitor.sv | 177 +++++++++++++++++
 tb/tb_approx_error_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/approx_error_monitor.sv
// approx_error_monitor: accumulates error metrics over a stream of
// (golden, approximate) primary-output word pairs. The metrics are error
// count, Hamming distance, absolute numeric error and worst-case error.
// Results are held in DONE until the next run is started.
module approx_error_monitor #(
  parameter int PO_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_vec,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PO_W-1:0]       gold,
  input  logic [PO_W-1:0]       approx,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      vec_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      bit_err_sum,
  output logic [CNT_W+PO_W-1:0] abs_err_sum,
  output logic [PO_W-1:0]       max_abs_err
);

  localparam int SUM_W = CNT_W + PO_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // |a - b| on unsigned operands, formed at PO_W+1 bits so the borrow is visible.
  function automatic logic [PO_W-1:0] abs_diff(input logic [PO_W-1:0] a,
                                               input logic [PO_W-1:0] b);
    logic [PO_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[PO_W]) begin
      d = {(PO_W+1){1'b0}} - d;
    end else begin
      d = d;
    end
    return d[PO_W-1:0];
  endfunction

  // Number of set bits in an output-word difference.
  function automatic logic [CNT_W-1:0] popcount(input logic [PO_W-1:0] x);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < PO_W; i++) begin
      c = c + CNT_W'(x[i]);
    end
    return c;
  endfunction

  // Counter-width add that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  // Sum-width add that sticks at all-ones instead of wrapping.
  function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                   input logic [SUM_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[SUM_W]) begin
      return {SUM_W{1'b1}};
    end else begin
      return s[SUM_W-1:0];
    end
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  num_vec_r, num_vec_s;
  logic [CNT_W-1:0]  vec_r, vec_s;
  logic [CNT_W-1:0]  err_r, err_s;
  logic [CNT_W-1:0]  bit_r, bit_s;
  logic [SUM_W-1:0]  abs_r, abs_s;
  logic [PO_W-1:0]   max_r, max_s;
  logic [PO_W-1:0]   diff_s;
  logic              mismatch_s;

  assign diff_s     = abs_diff(gold, approx);
  assign mismatch_s = (gold != approx);

  // Next-state and metric update: start handling in IDLE/DONE, accepts in RUN.
  always_comb begin
    state_s   = state_r;
    num_vec_s = num_vec_r;
    vec_s     = vec_r;
    err_s     = err_r;
    bit_s     = bit_r;
    abs_s     = abs_r;
    max_s     = max_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          vec_s = {CNT_W{1'b0}};
          err_s = {CNT_W{1'b0}};
          bit_s = {CNT_W{1'b0}};
          abs_s = {SUM_W{1'b0}};
          max_s = {PO_W{1'b0}};
          if (num_vec != {CNT_W{1'b0}}) begin
            num_vec_s = num_vec;
            state_s   = RUN;
          end else begin
            state_s   = DONE;
          end
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (in_valid) begin
          vec_s = sat_add_cnt(vec_r, {{(CNT_W-1){1'b0}}, 1'b1});
          err_s = sat_add_cnt(err_r, {{(CNT_W-1){1'b0}}, mismatch_s});
          bit_s = sat_add_cnt(bit_r, popcount(gold ^ approx));
          abs_s = sat_add_sum(abs_r, {{CNT_W{1'b0}}, diff_s});
          if (diff_s > max_r) begin
            max_s = diff_s;
          end else begin
            max_s = max_r;
          end
          if (vec_s == num_vec_r) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and metric registers; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      num_vec_r <= {CNT_W{1'b0}};
      vec_r     <= {CNT_W{1'b0}};
      err_r     <= {CNT_W{1'b0}};
      bit_r     <= {CNT_W{1'b0}};
      abs_r     <= {SUM_W{1'b0}};
      max_r     <= {PO_W{1'b0}};
    end else begin
      state_r   <= state_s;
      num_vec_r <= num_vec_s;
      vec_r     <= vec_s;
      err_r     <= err_s;
      bit_r     <= bit_s;
      abs_r     <= abs_s;
      max_r     <= max_s;
    end
  end

  assign in_ready    = (state_r == RUN);
  assign busy        = (state_r == RUN);
  assign done        = (state_r == DONE);
  assign vec_count   = vec_r;
  assign err_count   = err_r;
  assign bit_err_sum = bit_r;
  assign abs_err_sum = abs_r;
  assign max_abs_err = max_r;

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: directed test-plan runs plus randomized
// runs, checked every cycle against a plain-arithmetic model. A 16-bit
// counter instance and a 4-bit counter instance share all inputs so that
// saturation can be exercised.
module tb_approx_error_monitor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic        in_valid;
  logic [1:0]  gold;
  logic [1:0]  approx;

  logic        rdy_a, busy_a, done_a;
  logic [15:0] vec_a, err_a, bit_a;
  logic [17:0] abs_a;
  logic [1:0]  max_a;

  logic        rdy_b, busy_b, done_b;
  logic [3:0]  vec_b, err_b, bit_b;
  logic [5:0]  abs_b;
  logic [1:0]  max_b;

  int checks = 0;
  int errors = 0;

  // Model state per instance: phase 0 idle, 1 running, 2 finished.
  int mph[2], mnv[2], mvec[2], merr[2], mbit[2], mabs[2], mmax[2];
  int cap[2]  = '{65535, 15};
  int scap[2] = '{262143, 63};

  approx_error_monitor #(.PO_W(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(rdy_a), .gold(gold), .approx(approx),
    .busy(busy_a), .done(done_a), .vec_count(vec_a), .err_count(err_a),
    .bit_err_sum(bit_a), .abs_err_sum(abs_a), .max_abs_err(max_a)
  );

  approx_error_monitor #(.PO_W(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec[3:0]),
    .in_valid(in_valid), .in_ready(rdy_b), .gold(gold), .approx(approx),
    .busy(busy_b), .done(done_b), .vec_count(vec_b), .err_count(err_b),
    .bit_err_sum(bit_b), .abs_err_sum(abs_b), .max_abs_err(max_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int c);
    return (v > c) ? c : v;
  endfunction

  task automatic model_clear(input int k);
    mvec[k] = 0; merr[k] = 0; mbit[k] = 0; mabs[k] = 0; mmax[k] = 0;
  endtask

  // Applies the behavioural rules to the inputs present at this clock edge.
  task automatic model_edge();
    int g, a, d;
    g = int'(gold);
    a = int'(approx);
    d = (g > a) ? g - a : a - g;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mph[k] = 0;
        model_clear(k);
      end else if (mph[k] != 1) begin
        if (start) begin
          model_clear(k);
          mnv[k] = (k == 0) ? int'(num_vec) : int'(num_vec) % 16;
          mph[k] = (mnv[k] == 0) ? 2 : 1;
        end
      end else if (in_valid) begin
        mvec[k] = sat(mvec[k] + 1, cap[k]);
        merr[k] = sat(merr[k] + ((g != a) ? 1 : 0), cap[k]);
        mbit[k] = sat(mbit[k] + $countones(gold ^ approx), cap[k]);
        mabs[k] = sat(mabs[k] + d, scap[k]);
        if (d > mmax[k]) mmax[k] = d;
        if (mvec[k] == mnv[k]) mph[k] = 2;
      end
    end
  endtask

  task automatic check_all();
    check("a_in_ready", 64'(rdy_a),  64'(mph[0] == 1));
    check("a_busy",     64'(busy_a), 64'(mph[0] == 1));
    check("a_done",     64'(done_a), 64'(mph[0] == 2));
    check("a_vec",      64'(vec_a),  64'(mvec[0]));
    check("a_err",      64'(err_a),  64'(merr[0]));
    check("a_bit",      64'(bit_a),  64'(mbit[0]));
    check("a_abs",      64'(abs_a),  64'(mabs[0]));
    check("a_max",      64'(max_a),  64'(mmax[0]));
    check("b_in_ready", 64'(rdy_b),  64'(mph[1] == 1));
    check("b_busy",     64'(busy_b), 64'(mph[1] == 1));
    check("b_done",     64'(done_b), 64'(mph[1] == 2));
    check("b_vec",      64'(vec_b),  64'(mvec[1]));
    check("b_err",      64'(err_b),  64'(merr[1]));
    check("b_bit",      64'(bit_b),  64'(mbit[1]));
    check("b_abs",      64'(abs_b),  64'(mabs[1]));
    check("b_max",      64'(max_b),  64'(mmax[1]));
  endtask

  task automatic step(input logic r, input logic s, input int nv, input logic v,
                      input int g, input int a);
    rst = r; start = s; num_vec = 16'(nv); in_valid = v;
    gold = 2'(g); approx = 2'(a);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int idx;
    int nv;
    logic v;
    int g;
    logic [6:0] pat;

    rst = 1'b1; start = 1'b0; num_vec = 16'd0; in_valid = 1'b0;
    gold = 2'd0; approx = 2'd0;
    for (int k = 0; k < 2; k++) begin
      mph[k] = 0; mnv[k] = 0; model_clear(k);
    end
    #1;

    // Reset state
    step(1'b1, 1'b0, 0, 1'b1, 3, 0);
    step(1'b1, 1'b1, 5, 1'b1, 3, 0);
    check("rst_ready", 64'(rdy_a), 64'd0);
    check("rst_done",  64'(done_a), 64'd0);
    check("rst_vec",   64'(vec_a), 64'd0);

    // Exact match, 32 vectors
    step(1'b0, 1'b1, 32, 1'b0, 0, 0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 0, 1'b1, i % 4, i % 4);
    check("t1_done", 64'(done_a), 64'd1);
    check("t1_vec",  64'(vec_a),  64'd32);
    check("t1_err",  64'(err_a),  64'd0);
    check("t1_abs",  64'(abs_a),  64'd0);
    step(1'b0, 1'b0, 0, 1'b1, 3, 0);
    check("t1_frozen", 64'(vec_a), 64'd32);

    // Injected errors at vectors 3, 10, 31 with random gaps
    step(1'b0, 1'b1, 32, 1'b0, 0, 0);
    idx = 0;
    for (int c = 0; c < 400 && mph[0] != 2; c++) begin
      v = ($urandom_range(0, 3) != 0);
      g = $urandom_range(0, 3);
      if (idx == 2 || idx == 9 || idx == 30) step(1'b0, 1'b0, 0, v, 3, 0);
      else step(1'b0, 1'b0, 0, v, g, g);
      if (v) idx++;
    end
    check("t2_finished", 64'(mph[0]), 64'd2);
    check("t2_err", 64'(err_a), 64'd3);
    check("t2_bit", 64'(bit_a), 64'd6);
    check("t2_abs", 64'(abs_a), 64'd9);
    check("t2_max", 64'(max_a), 64'd3);

    // Backpressure and gaps: valid 1,0,0,1,1,0,1 then held high
    step(1'b0, 1'b1, 4, 1'b0, 0, 0);
    pat = 7'b1011001;
    for (int i = 0; i < 12; i++) begin
      v = (i < 7) ? pat[i] : 1'b1;
      step(1'b0, 1'b0, 0, v, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    check("t3_vec",   64'(vec_a), 64'd4);
    check("t3_ready", 64'(rdy_a), 64'd0);

    // Zero-length run, then restart from DONE
    step(1'b0, 1'b1, 0, 1'b0, 0, 0);
    check("t4_zero_done", 64'(done_a), 64'd1);
    check("t4_zero_vec",  64'(vec_a),  64'd0);
    step(1'b0, 1'b1, 2, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 1'b1, 1, 2);
    step(1'b0, 1'b0, 0, 1'b1, 3, 3);
    check("t4_done", 64'(done_a), 64'd1);
    check("t4_err",  64'(err_a),  64'd1);
    check("t4_bit",  64'(bit_a),  64'd2);
    check("t4_abs",  64'(abs_a),  64'd1);
    check("t4_max",  64'(max_a),  64'd1);

    // Reset mid-run (with a simultaneous start), then start honoured
    step(1'b0, 1'b1, 32, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 1'b1, 3, 1);
    step(1'b1, 1'b1, 5, 1'b1, 3, 0);
    check("t5_ready", 64'(rdy_a), 64'd0);
    check("t5_vec",   64'(vec_a), 64'd0);
    check("t5_abs",   64'(abs_a), 64'd0);
    step(1'b0, 1'b1, 5, 1'b0, 0, 0);
    check("t5_busy", 64'(busy_a), 64'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b1, 2, 0);
    check("t5_abs_end", 64'(abs_a), 64'd10);

    // Saturation on the 4-bit counter instance
    step(1'b0, 1'b1, 15, 1'b0, 0, 0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 0, 1'b1, 3, 0);
    check("t6_b_done", 64'(done_b), 64'd1);
    check("t6_b_err",  64'(err_b),  64'd15);
    check("t6_b_bit",  64'(bit_b),  64'd15);
    check("t6_b_abs",  64'(abs_b),  64'd45);
    check("t6_b_max",  64'(max_b),  64'd3);
    check("t6_a_bit",  64'(bit_a),  64'd30);

    // Randomized runs with gaps and ignored start pulses
    for (int r = 0; r < 6; r++) begin
      nv = $urandom_range(1, 40);
      step(1'b0, 1'b1, nv, 1'b0, 0, 0);
      for (int c = 0; c < 300 && mph[0] != 2; c++) begin
        step(1'b0, ($urandom_range(0, 7) == 0), $urandom_range(0, 40),
             ($urandom_range(0, 2) != 0), $urandom_range(0, 3), $urandom_range(0, 3));
      end
      check("t7_finished", 64'(mph[0]), 64'd2);
      check("t7_vec", 64'(vec_a), 64'(nv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
